sum_bcd_display: RTL
====================

// Module: sum_bcd_display
// PURPOSE
//  Downstream stage of the 4-bit adder: consumes its 5-bit sum (0..31).
//  Converts the sum to two BCD digits with a sequential double-dabble FSM.
//  Time-multiplexes the two digits onto a 2-digit common-anode 7-segment display.
//  Exposes busy and the BCD digits so the bench can observe them.
// PARAMETERS
//  SCAN_DIV  50000  clock cycles each digit stays enabled (>=2)
// PORTS
//  clk        in   1  system clock; all state changes on its rising edge
//  rst        in   1  synchronous, active-high reset
//  sum_in     in   5  adder sum, unsigned 0..31, may change any cycle
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit)
//  dig_sel    out  2  digit enables, active-low; [0]=ones, [1]=tens
//  bcd_tens   out  4  tens digit of last completed conversion
//  bcd_ones   out  4  ones digit of last completed conversion
//  busy       out  1  high while a conversion is in progress
// BEHAVIOUR
//  Reset values: sum_q=0, last_conv=0, state=IDLE, busy=0, bcd_tens=0, bcd_ones=0,
//   scan_cnt=0, digit index=ones, dig_sel=2'b10, seg=7'b1000000 ('0').
//  Input sampling: sum_in is registered into sum_q every cycle.
//  FSM states and transitions:
//   IDLE  -> SHIFT when sum_q != last_conv.
//            Transition loads the shift register with {8'b0, sum_q}, sets last_conv=sum_q, it=0.
//   SHIFT -> one iteration per cycle, 5 cycles total (it 0..4).
//            Per iteration: add 3 to each BCD nibble that is >=5, then shift the whole
//            register left by 1. Goes to DONE after it==4.
//   DONE  -> registers bcd_tens/bcd_ones from the shift register; returns to IDLE.
//  Latency: edge E0 captures new sum_in into sum_q. E1 enters SHIFT. E2..E6 perform
//   the shifts. E7 updates bcd_* and returns to IDLE. busy=(state!=IDLE), high 6 cycles.
//  sum_in change during a conversion:
//   - The current conversion completes unchanged.
//   - The FSM then sees sum_q != last_conv in IDLE and restarts (1 idle cycle between).
//   - Intermediate values that never reach sum_q while in IDLE are skipped.
//   - bcd_* only ever hold complete, correct results.
//  Range: 31 -> tens=3, ones=1. Tens never exceeds 3. No overflow indication.
//  Scan:
//   - scan_cnt counts 0..SCAN_DIV-1 and wraps.
//   - On the wrap edge the digit index toggles.
//   - dig_sel and seg are registered together in the same cycle as the toggle:
//     ones -> dig_sel=2'b10, seg=enc(bcd_ones); tens -> dig_sel=2'b01, seg=enc(bcd_tens).
//   - seg also updates on any cycle where the displayed bcd digit changes.
//  Encoding (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000,
//   4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//   Any other nibble displays 1111111.
//  Reset mid-conversion: the sync reset aborts the conversion.
//   - All registers return to reset values.
//   - A nonzero sum_in held through reset starts a fresh conversion: sampled at the
//     first edge after rst falls, SHIFT entered at the next edge.
// CONFIGURATION
//  SUM_BCD_BLANK_EN defined: leading-zero blanking. While the tens digit is displayed
//   and bcd_tens==0, seg=7'b1111111 (dig_sel unchanged).
//  Not defined: the tens digit always shows its value, including '0' (1000000).
// TESTING (SCAN_DIV=4 unless noted)
//  1 Reset with sum_in=0 -> busy stays 0; dig_sel=10, seg=1000000; no conversion starts.
//  2 sum_in=19 at E0 -> busy high E1..E7 (6 cycles); bcd_tens=1, bcd_ones=9 after E7.
//  3 Scan check after test 2 -> dig_sel alternates 10/01 every 4 cycles;
//    seg=0010000 on ones, 1111001 on tens.
//  4 sum_in=7, then 30 on the 3rd busy cycle -> bcd becomes 0/7, then 3/0;
//    busy low exactly 1 cycle between the two conversions.
//  5 sum_in=31 -> bcd 3/1. sum_in=4 -> tens seg=1111111 with SUM_BCD_BLANK_EN,
//    1000000 without it.
//  6 sum_in=25, assert rst on the 3rd SHIFT cycle for 1 cycle with sum_in held
//    -> bcd 0/0 and busy=0 during reset; restarts; bcd 2/5 at the 8th edge after rst falls.

Source files
------------

// File: rtl/sum_bcd_display.sv
// Converts a 5-bit sum to two BCD digits with a sequential double-dabble FSM and scans them onto a 2-digit 7-segment display.
// Optional leading-zero blanking of the tens digit: define SUM_BCD_BLANK_EN.
module sum_bcd_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [4:0]    sum_q, last_conv_q;
  logic [12:0]   sr_q;
  logic [2:0]    it_q;
  logic [3:0]    bcd_tens_q, bcd_ones_q, bcd_tens_d, bcd_ones_d;
  logic [CW-1:0] scan_cnt_q;
  logic          digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_sel_q;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [12:0] dd_step(input logic [12:0] s);
    logic [12:0] t;
    t = s;
    if (t[8:5] >= 4'd5)  t[8:5]  = t[8:5] + 4'd3;
    if (t[12:9] >= 4'd5) t[12:9] = t[12:9] + 4'd3;
    dd_step = {t[11:0], 1'b0};
  endfunction

  // Display path looks at next-state digits so seg tracks a new result on the same edge.
  always_comb begin
    bcd_tens_d = bcd_tens_q;
    bcd_ones_d = bcd_ones_q;
    if (state_q == DONE) begin
      bcd_tens_d = sr_q[12:9];
      bcd_ones_d = sr_q[8:5];
    end
    digit_d = digit_q ^ (scan_cnt_q == SCAN_MAX);
    seg_d   = enc(digit_d ? bcd_tens_d : bcd_ones_d);
`ifdef SUM_BCD_BLANK_EN
    if (digit_d && (bcd_tens_d == 4'd0)) seg_d = 7'b1111111;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= 5'd0;
      last_conv_q <= 5'd0;
      sr_q        <= 13'd0;
      it_q        <= 3'd0;
      bcd_tens_q  <= 4'd0;
      bcd_ones_q  <= 4'd0;
      scan_cnt_q  <= '0;
      digit_q     <= 1'b0;
      dig_sel_q   <= 2'b10;
      seg_q       <= 7'b1000000;
    end else begin
      sum_q      <= sum_in;
      bcd_tens_q <= bcd_tens_d;
      bcd_ones_q <= bcd_ones_d;
      case (state_q)
        IDLE: begin
          if (sum_q != last_conv_q) begin
            sr_q        <= {8'b0, sum_q};
            last_conv_q <= sum_q;
            it_q        <= 3'd0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q <= dd_step(sr_q);
          it_q <= it_q + 3'd1;
          if (it_q == 3'd4) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      scan_cnt_q <= (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + 1'b1;
      digit_q    <= digit_d;
      dig_sel_q  <= digit_d ? 2'b01 : 2'b10;
      seg_q      <= seg_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign bcd_tens = bcd_tens_q;
  assign bcd_ones = bcd_ones_q;
  assign seg      = seg_q;
  assign dig_sel  = dig_sel_q;

endmodule
